speed_to_rpm: RTL and testbench

Converts the averaged pulse-period word from the speed-measurement stage into an unsigned revolutions-per-minute value. The block sits directly downstream of the speed measurement: it watches the 32-bit period input and starts a new conversion whenever the value changes. Each conversion is one bit-serial restoring division of a compile-time constant by that period. It also produces stall and saturation flags for the motor controller.

---
 rtl/speed_to_rpm_pkg.sv | 14 +
 rtl/speed_to_rpm_serial_div.sv | 55 +++++
 rtl/speed_to_rpm.sv | 124 ++++++++++++
 tb/tb_speed_to_rpm.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/speed_to_rpm_pkg.sv
// Shared types and constants for the period-to-RPM converter.
package speed_pkg;

  localparam int NUM_W = 40;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    DONE = 2'd2
  } spd_state_t;

  localparam logic [15:0] RPM_MAX = 16'hFFFF;

endpackage

// File: rtl/speed_to_rpm_serial_div.sv
// Bit-serial restoring divider: one quotient bit per cycle, DW cycles per result.
// The divisor must stay stable while a division is running.
module serial_div #(
  parameter int DW = 40,
  parameter int VW = 32
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          start,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          done,
  output logic [DW-1:0] quotient
);

  localparam logic [5:0] LAST = 6'(DW - 1);

  logic [DW-1:0] quot;
  logic [VW:0]   rem;
  logic [5:0]    cnt;
  logic          run;
  logic [VW+1:0] rem_sh;
  logic          ge;
  logic [VW:0]   diff;

  // Remainder stays below the divisor, so the difference always fits in VW+1 bits.
  always_comb begin
    rem_sh = {rem, quot[DW-1]};
    ge     = rem_sh >= {2'b00, divisor};
    diff   = rem_sh[VW:0] - {1'b0, divisor};
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      quot <= '0;
      rem  <= '0;
      cnt  <= '0;
      run  <= 1'b0;
    end else if (start) begin
      quot <= dividend;
      rem  <= '0;
      cnt  <= '0;
      run  <= 1'b1;
    end else if (run) begin
      quot <= {quot[DW-2:0], ge};
      rem  <= ge ? diff : rem_sh[VW:0];
      cnt  <= cnt + 6'd1;
      if (cnt == LAST) run <= 1'b0;
    end
  end

  assign done     = run && (cnt == LAST);
  assign quotient = quot;

endmodule

// File: rtl/speed_to_rpm.sv
// Converts the averaged pulse period into saturated RPM with stall/overflow flags.
// SPEED_TO_RPM_ROUND_EN selects round-to-nearest division (one extra step).
//   state | meaning
//   IDLE  | waiting for SPEED to differ from the latched operand
//   DIV   | serial division of NUM by op in progress
//   DONE  | register RPM/flags and pulse RPM_VALID
module speed_to_rpm
  import speed_pkg::*;
#(
  parameter int unsigned CLK_HZ       = 50_000_000,
  parameter int unsigned PPR          = 1,
  parameter int unsigned MEAS_PULSES  = 4,
  parameter int unsigned STALL_CYCLES = 50_000_000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] SPEED,
  output logic [15:0] RPM,
  output logic        RPM_VALID,
  output logic        STALL,
  output logic        OVF,
  output logic        BUSY
);

  localparam logic [63:0] NUM_FULL = 64'd60 * 64'(CLK_HZ) * 64'(MEAS_PULSES) / 64'(PPR);
  localparam logic [63:0] NUM_LIM  = (64'd1 << NUM_W) - 64'd1;
  localparam logic [NUM_W-1:0] NUM = NUM_FULL[NUM_W-1:0];

  if (NUM_FULL > NUM_LIM) begin : g_num_check
    $error("speed_to_rpm: numerator does not fit in NUM_W bits");
  end

`ifdef SPEED_TO_RPM_ROUND_EN
  localparam int DIV_W = NUM_W + 1;
  logic [DIV_W-1:0] dividend;
  // Adding half the divisor turns truncation into round-to-nearest.
  assign dividend = {1'b0, NUM} + {10'd0, SPEED[31:1]};
`else
  localparam int DIV_W = NUM_W;
  logic [DIV_W-1:0] dividend;
  assign dividend = NUM;
`endif

  spd_state_t       state;
  spd_state_t       next_state;
  logic [31:0]      op;
  logic             stall_flag;
  logic             mismatch;
  logic             special;
  logic             start_div;
  logic             div_done;
  logic [DIV_W-1:0] div_quot;
  logic             over;

  assign mismatch = SPEED != op;
  assign special  = (SPEED == 32'd0) || (SPEED >= STALL_CYCLES);
  assign over     = |div_quot[DIV_W-1:16];

  serial_div #(
    .DW (DIV_W),
    .VW (32)
  ) u_div (
    .CLK      (CLK),
    .RST      (RST),
    .start    (start_div),
    .dividend (dividend),
    .divisor  (op),
    .done     (div_done),
    .quotient (div_quot)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (mismatch) next_state = special ? DONE : DIV;
      DIV:  if (div_done) next_state = DONE;
      DONE: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    start_div = 1'b0;
    BUSY      = 1'b0;
    case (state)
      IDLE: start_div = mismatch && !special;
      DIV:  BUSY = 1'b1;
      DONE: BUSY = 1'b1;
      default: BUSY = 1'b0;
    endcase
  end

  // Zero/stall results bypass the divider and report a zero quotient.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      op         <= '0;
      stall_flag <= 1'b0;
      RPM        <= '0;
      RPM_VALID  <= 1'b0;
      STALL      <= 1'b0;
      OVF        <= 1'b0;
    end else begin
      RPM_VALID <= 1'b0;
      if (state == IDLE && mismatch) begin
        op         <= SPEED;
        stall_flag <= special;
      end
      if (state == DONE) begin
        RPM_VALID <= 1'b1;
        STALL     <= stall_flag;
        OVF       <= !stall_flag && over;
        if (stall_flag)  RPM <= '0;
        else if (over)   RPM <= RPM_MAX;
        else             RPM <= div_quot[15:0];
      end
    end
  end

endmodule

// File: tb/tb_speed_to_rpm.sv
// Scoreboard bench for speed_to_rpm against an arithmetic reference model.
module tb_speed_to_rpm;

  localparam longint unsigned NUM_TB   = 64'd60 * 64'd50_000_000 * 64'd4;
  localparam int unsigned     STALL_TB = 50_000_000;
`ifdef SPEED_TO_RPM_ROUND_EN
  localparam int LAT   = 42;
  localparam bit ROUND = 1'b1;
`else
  localparam int LAT   = 41;
  localparam bit ROUND = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [31:0] SPEED = 32'd0;
  logic [15:0] RPM;
  logic        RPM_VALID;
  logic        STALL;
  logic        OVF;
  logic        BUSY;

  speed_to_rpm dut (
    .CLK       (CLK),
    .RST       (RST),
    .SPEED     (SPEED),
    .RPM       (RPM),
    .RPM_VALID (RPM_VALID),
    .STALL     (STALL),
    .OVF       (OVF),
    .BUSY      (BUSY)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int rpm;
    bit stall;
    bit ovf;
    int at;
  } exp_t;

  exp_t  sb_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;
  int    cyc      = 0;
  logic [31:0] m_op = 32'd0;
  int    m_next   = 0;
  int    m_done   = 0;
  int    last_rpm = 0;
  exp_t  m_e;
  exp_t  mon_e;
  longint unsigned m_q;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: a change of SPEED is taken at the first free edge; result after fixed latency.
  always @(posedge CLK) begin
    cyc++;
    if (!RST && cyc >= m_next && SPEED != m_op) begin
      m_op = SPEED;
      if (SPEED == 32'd0 || SPEED >= STALL_TB) begin
        m_e.rpm = 0; m_e.stall = 1'b1; m_e.ovf = 1'b0; m_e.at = cyc + 1;
      end else begin
        m_q = (NUM_TB + (ROUND ? 64'(SPEED >> 1) : 64'd0)) / 64'(SPEED);
        m_e.stall = 1'b0;
        m_e.ovf   = m_q > 64'd65535;
        m_e.rpm   = m_e.ovf ? 65535 : int'(m_q);
        m_e.at    = cyc + LAT;
      end
      m_done = m_e.at;
      m_next = m_e.at + 1;
      sb_q.push_back(m_e);
    end
  end

  always @(posedge RST) begin
    sb_q.delete();
    m_op     = 32'd0;
    m_next   = 0;
    m_done   = 0;
    last_rpm = 0;
  end

  always @(negedge CLK) begin
    if (!RST) begin
      check("busy", BUSY, (cyc < m_done) ? 1 : 0);
      if (sb_q.size() > 0 && cyc > sb_q[0].at) begin
        n_checks++; n_fail++;
        $display("FAIL missed_valid: no RPM_VALID by cycle %0d, expected at %0d", cyc, sb_q[0].at);
        void'(sb_q.pop_front());
      end
      if (RPM_VALID) begin
        if (sb_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_valid: RPM_VALID=1 with RPM=%0d, none expected (cycle %0d)", RPM, cyc);
        end else begin
          mon_e = sb_q.pop_front();
          check("rpm", RPM, mon_e.rpm);
          check("stall", STALL, mon_e.stall);
          check("ovf", OVF, mon_e.ovf);
          check("valid_cycle", cyc, mon_e.at);
          last_rpm = mon_e.rpm;
        end
      end else begin
        check("rpm_hold", RPM, last_rpm);
      end
    end
  end

  task automatic set_speed(input logic [31:0] v);
    @(negedge CLK);
    SPEED = v;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (!(sb_q.size() == 0 && cyc >= m_next && SPEED == m_op && !BUSY) && n < budget) begin
      @(negedge CLK);
      n++;
    end
    if (n >= budget) begin
      n_checks++; n_fail++;
      $display("FAIL wait_idle: timeout after %0d cycles, %0d results pending", n, sb_q.size());
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_rpm"}, RPM, 0);
    check({tag, "_valid"}, RPM_VALID, 0);
    check({tag, "_stall"}, STALL, 0);
    check({tag, "_ovf"}, OVF, 0);
    check({tag, "_busy"}, BUSY, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    logic [31:0] v;
    RST   = 1'b1;
    SPEED = 32'd2_000_000;
    repeat (3) @(negedge CLK);
    check_zero_outputs("reset");
    RST = 1'b0;
    wait_idle(200);

    set_speed(32'd100_000);
    wait_idle(200);

    set_speed(32'd50_000_000);
    repeat (3) @(negedge CLK);
    SPEED = 32'd0;
    wait_idle(200);

    set_speed(32'd3_000_001);
    wait_idle(200);

    set_speed(32'd1);
    wait_idle(200);

    set_speed(32'd2_000_000);
    repeat (20) @(posedge CLK);
    @(negedge CLK);
    SPEED = 32'd4_000_000;
    wait_idle(300);
    repeat (100) @(negedge CLK);

    set_speed(32'd2_000_000);
    repeat (16) @(posedge CLK);
    #2 RST = 1'b1;
    #1 check_zero_outputs("midrst");
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    wait_idle(200);

    for (int i = 0; i < 40; i++) begin
      k = int'($urandom_range(0, 9));
      case (k)
        0:       v = 32'd0;
        1:       v = $urandom_range(1, 183_000);
        2:       v = $urandom_range(183_000, 183_300);
        3:       v = STALL_TB - 32'd1 + $urandom_range(0, 1);
        4:       v = SPEED;
        5:       v = $urandom();
        default: v = $urandom_range(183_000, 49_999_999);
      endcase
      set_speed(v);
      repeat ($urandom_range(1, 60)) @(negedge CLK);
    end
    wait_idle(300);
    repeat (50) @(negedge CLK);
    check("sb_empty", sb_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
